// File: rtl/energy_detector_pkg.sv
// Shared types and default widths for the energy_detector decision stage.
package energy_detector_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    DECIDE = 2'd2
  } state_t;

  localparam int ACC_W_DEFAULT   = 32;
  localparam int THRES_W_DEFAULT = 12;
  localparam int FRAC_W_DEFAULT  = 4;
  localparam int PROD_W_DEFAULT  = ACC_W_DEFAULT + THRES_W_DEFAULT;

endpackage

// File: rtl/energy_detector_if.sv
// Window-sum input and decision output bundle of energy_detector.
interface energy_detector_if import energy_detector_pkg::*; #(
  parameter int ACC_W   = ACC_W_DEFAULT,
  parameter int THRES_W = THRES_W_DEFAULT,
  parameter int M_WIN   = 8,
  localparam int CNT_W  = $clog2(M_WIN + 1)
);

  logic               done;
  logic [ACC_W-1:0]   signal_in;
  logic [ACC_W-1:0]   noise_in;
  logic [THRES_W-1:0] thres;
  logic               busy;
  logic               valid;
  logic               hit;
  logic               detect;
  logic [CNT_W-1:0]   hit_count;
  logic [ACC_W-1:0]   signal_latch;

  modport master (
    output done, signal_in, noise_in, thres,
    input  busy, valid, hit, detect, hit_count, signal_latch
  );

  modport slave (
    input  done, signal_in, noise_in, thres,
    output busy, valid, hit, detect, hit_count, signal_latch
  );

endinterface

// File: rtl/energy_detector_shift_add_mult.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle, LSB first.
module shift_add_mult import energy_detector_pkg::*; #(
  parameter int  A_W   = ACC_W_DEFAULT,
  parameter int  B_W   = THRES_W_DEFAULT,
  localparam int P_W   = A_W + B_W,
  localparam int CNT_W = $clog2(B_W + 1)
) (
  input  logic           clk,
  input  logic           aclr,
  input  logic           start,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [P_W-1:0] product,
  output logic           done_pulse
);

  logic [CNT_W-1:0] cnt;
  logic [P_W-1:0]   a_sh;
  logic [B_W-1:0]   b_sh;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr)            cnt <= '0;
    else if (start)      cnt <= CNT_W'(B_W);
    else if (cnt != '0)  cnt <= cnt - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (start) begin
      a_sh    <= P_W'(a);
      b_sh    <= b;
      product <= '0;
    end else if (cnt != '0) begin
      if (b_sh[0]) product <= product + a_sh;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
    end
  end

  // Flags the final iteration, so product is complete after the coming edge.
  assign done_pulse = (cnt == CNT_W'(1));

endmodule

// File: rtl/energy_detector.sv
// Window energy decision with N-of-M persistence filter.
// Optional ENERGY_DETECTOR_OVERRUN_EN adds a saturating dropped-window counter.
module energy_detector import energy_detector_pkg::*; #(
  parameter int ACC_W   = ACC_W_DEFAULT,
  parameter int THRES_W = THRES_W_DEFAULT,
  parameter int FRAC_W  = FRAC_W_DEFAULT,
  parameter int M_WIN   = 8,
  parameter int N_HIT   = 5
) (
  input  logic             clk,
  input  logic             aclr,
  energy_detector_if.slave io
`ifdef ENERGY_DETECTOR_OVERRUN_EN
  ,
  output logic [7:0]       overrun_cnt
`endif
);

  localparam int PROD_W = ACC_W + THRES_W;
  localparam int CNT_W  = $clog2(M_WIN + 1);

  state_t            state, next_state;
  logic              start, decide, busy_d, mult_last;
  logic [PROD_W-1:0] product;
  logic [ACC_W-1:0]  sig_p0;
  logic [M_WIN-1:0]  hist, hist_new;
  logic              hit_new;
  logic [CNT_W-1:0]  cnt_new;

  function automatic logic exceeds(input logic [ACC_W-1:0] s, input logic [PROD_W-1:0] p);
    return PROD_W'({s, {FRAC_W{1'b0}}}) > p;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [M_WIN-1:0] h);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < M_WIN; i++) c = c + CNT_W'(h[i]);
    return c;
  endfunction

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (io.done) next_state = MULT;
      MULT:    if (mult_last) next_state = DECIDE;
      DECIDE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    start  = (state == IDLE) && io.done;
    decide = (state == DECIDE);
    busy_d = (next_state != IDLE);
  end

  shift_add_mult #(.A_W(ACC_W), .B_W(THRES_W)) u_mult (
    .clk        (clk),
    .aclr       (aclr),
    .start      (start),
    .a          (io.noise_in),
    .b          (io.thres),
    .product    (product),
    .done_pulse (mult_last)
  );

  // Capture stage: noise and threshold are held inside the multiplier.
  always_ff @(posedge clk) begin
    if (start) sig_p0 <= io.signal_in;
  end

  assign hit_new  = exceeds(sig_p0, product);
  assign hist_new = {hist[M_WIN-2:0], hit_new};
  assign cnt_new  = popcount(hist_new);

  // Decision stage: all outputs registered and held between decisions.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      io.busy         <= 1'b0;
      io.valid        <= 1'b0;
      io.hit          <= 1'b0;
      io.detect       <= 1'b0;
      io.hit_count    <= '0;
      io.signal_latch <= '0;
      hist            <= '0;
    end else begin
      io.busy  <= busy_d;
      io.valid <= decide;
      if (decide) begin
        hist            <= hist_new;
        io.hit          <= hit_new;
        io.hit_count    <= cnt_new;
        io.detect       <= (cnt_new >= CNT_W'(N_HIT));
        io.signal_latch <= sig_p0;
      end
    end
  end

`ifdef ENERGY_DETECTOR_OVERRUN_EN
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr)
      overrun_cnt <= 8'h00;
    else if (io.done && (state != IDLE) && (overrun_cnt != 8'hFF))
      overrun_cnt <= overrun_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_energy_detector.sv
// Directed-vector bench for energy_detector (default parameters).
module tb_energy_detector;

  logic clk = 1'b0;
  logic aclr;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  energy_detector_if #(.ACC_W(32), .THRES_W(12), .M_WIN(8)) io ();

`ifdef ENERGY_DETECTOR_OVERRUN_EN
  logic [7:0] overrun_cnt;
`endif

  energy_detector #(.ACC_W(32), .THRES_W(12), .FRAC_W(4), .M_WIN(8), .N_HIT(5)) dut (
    .clk  (clk),
    .aclr (aclr),
    .io   (io)
`ifdef ENERGY_DETECTOR_OVERRUN_EN
    ,
    .overrun_cnt (overrun_cnt)
`endif
  );

  task automatic do_reset();
    aclr = 1'b1;
    io.done = 1'b0;
    io.signal_in = '0;
    io.noise_in = '0;
    io.thres = '0;
    @(negedge clk);
    @(negedge clk);
    aclr = 1'b0;
    @(negedge clk);
  endtask

  // Entered and left at a negedge; returns cycles from done edge to valid, -1 on timeout.
  task automatic run_window(input logic [31:0] s, input logic [31:0] n, input logic [11:0] t,
                            output int lat);
    io.signal_in = s;
    io.noise_in = n;
    io.thres = t;
    io.done = 1'b1;
    @(negedge clk);
    io.done = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (io.valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (io.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b want 0", io.busy); end
    vectors++; if (io.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b want 0", io.valid); end
    vectors++; if (io.hit !== 1'b0) begin miscompares++; $display("FAIL reset_hit: got %0b want 0", io.hit); end
    vectors++; if (io.detect !== 1'b0) begin miscompares++; $display("FAIL reset_detect: got %0b want 0", io.detect); end
    vectors++; if (io.hit_count !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", io.hit_count); end
    vectors++; if (io.signal_latch !== 32'd0) begin miscompares++; $display("FAIL reset_latch: got %0h want 0", io.signal_latch); end
`ifdef ENERGY_DETECTOR_OVERRUN_EN
    vectors++; if (overrun_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_overrun: got %0d want 0", overrun_cnt); end
`endif
  endtask

  task automatic test_threshold_equal();
    int   lat;
    logic b0, b12, b13;
    io.signal_in = 32'd100;
    io.noise_in = 32'd50;
    io.thres = 12'h020;
    io.done = 1'b1;
    @(negedge clk);
    io.done = 1'b0;
    b0 = io.busy;
    b12 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 12) b12 = io.busy;
      if (io.valid) begin
        lat = i;
        break;
      end
    end
    b13 = io.busy;
    vectors++; if (b0 !== 1'b1) begin miscompares++; $display("FAIL eq_busy_e0: got %0b want 1", b0); end
    vectors++; if (b12 !== 1'b1) begin miscompares++; $display("FAIL eq_busy_e12: got %0b want 1", b12); end
    vectors++; if (lat !== 13) begin miscompares++; $display("FAIL eq_latency: got %0d want 13", lat); end
    vectors++; if (b13 !== 1'b0) begin miscompares++; $display("FAIL eq_busy_e13: got %0b want 0", b13); end
    vectors++; if (io.hit !== 1'b0) begin miscompares++; $display("FAIL eq_hit: got %0b want 0", io.hit); end
    vectors++; if (io.hit_count !== 4'd0) begin miscompares++; $display("FAIL eq_count: got %0d want 0", io.hit_count); end
    vectors++; if (io.detect !== 1'b0) begin miscompares++; $display("FAIL eq_detect: got %0b want 0", io.detect); end
    vectors++; if (io.signal_latch !== 32'd100) begin miscompares++; $display("FAIL eq_latch: got %0d want 100", io.signal_latch); end
    @(negedge clk);
    vectors++; if (io.valid !== 1'b0) begin miscompares++; $display("FAIL eq_valid_pulse: got %0b want 0", io.valid); end
  endtask

  task automatic test_threshold_above();
    int lat;
    run_window(32'd101, 32'd50, 12'h020, lat);
    vectors++; if (lat !== 13) begin miscompares++; $display("FAIL above_latency: got %0d want 13", lat); end
    vectors++; if (io.hit !== 1'b1) begin miscompares++; $display("FAIL above_hit: got %0b want 1", io.hit); end
    vectors++; if (io.hit_count !== 4'd1) begin miscompares++; $display("FAIL above_count: got %0d want 1", io.hit_count); end
    vectors++; if (io.detect !== 1'b0) begin miscompares++; $display("FAIL above_detect: got %0b want 0", io.detect); end
    vectors++; if (io.signal_latch !== 32'd101) begin miscompares++; $display("FAIL above_latch: got %0d want 101", io.signal_latch); end
  endtask

  task automatic test_fractional();
    int lat;
    // 37 * 8.3125 = 307.5625 -> 4921/16; 300*16=4800, 308*16=4928.
    run_window(32'd300, 32'd37, 12'h085, lat);
    vectors++; if (lat !== 13) begin miscompares++; $display("FAIL frac_lat0: got %0d want 13", lat); end
    vectors++; if (io.hit !== 1'b0) begin miscompares++; $display("FAIL frac_hit_below: got %0b want 0", io.hit); end
    run_window(32'd308, 32'd37, 12'h085, lat);
    vectors++; if (io.hit !== 1'b1) begin miscompares++; $display("FAIL frac_hit_above: got %0b want 1", io.hit); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int exp_cnt[9] = '{1, 2, 3, 4, 5, 5, 5, 5, 4};
    int exp_det[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    do_reset();
    for (int k = 0; k < 9; k++) begin
      run_window((k < 5) ? 32'd101 : 32'd100, 32'd50, 12'h020, lat);
      vectors++; if (lat !== 13) begin miscompares++; $display("FAIL b2b_latency[%0d]: got %0d want 13", k, lat); end
      vectors++; if (io.hit_count !== 4'(exp_cnt[k])) begin miscompares++; $display("FAIL b2b_count[%0d]: got %0d want %0d", k, io.hit_count, exp_cnt[k]); end
      vectors++; if (io.detect !== 1'(exp_det[k])) begin miscompares++; $display("FAIL b2b_detect[%0d]: got %0b want %0d", k, io.detect, exp_det[k]); end
    end
  endtask

  task automatic test_dropped_done();
    int nvalid;
    do_reset();
    io.signal_in = 32'd100;
    io.noise_in = 32'd50;
    io.thres = 12'h020;
    io.done = 1'b1;
    @(negedge clk);
    io.done = 1'b0;
    repeat (4) @(negedge clk);
    io.signal_in = 32'd7;
    io.noise_in = 32'd0;
    io.thres = 12'h000;
    io.done = 1'b1;
    @(negedge clk);
    io.done = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (io.valid) nvalid++;
    end
    vectors++; if (nvalid !== 1) begin miscompares++; $display("FAIL drop_valid_count: got %0d want 1", nvalid); end
    vectors++; if (io.hit !== 1'b0) begin miscompares++; $display("FAIL drop_hit: got %0b want 0", io.hit); end
    vectors++; if (io.signal_latch !== 32'd100) begin miscompares++; $display("FAIL drop_latch: got %0d want 100", io.signal_latch); end
`ifdef ENERGY_DETECTOR_OVERRUN_EN
    vectors++; if (overrun_cnt !== 8'd1) begin miscompares++; $display("FAIL drop_overrun: got %0d want 1", overrun_cnt); end
`endif
  endtask

  task automatic test_abort();
    int lat;
    int nvalid;
    do_reset();
    run_window(32'd101, 32'd50, 12'h020, lat);
    io.signal_in = 32'd55;
    io.done = 1'b1;
    @(negedge clk);
    io.done = 1'b0;
    repeat (5) @(negedge clk);
    aclr = 1'b1;
    #1;
    vectors++; if (io.busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %0b want 0", io.busy); end
    vectors++; if (io.hit !== 1'b0) begin miscompares++; $display("FAIL abort_hit: got %0b want 0", io.hit); end
    vectors++; if (io.hit_count !== 4'd0) begin miscompares++; $display("FAIL abort_count: got %0d want 0", io.hit_count); end
    vectors++; if (io.signal_latch !== 32'd0) begin miscompares++; $display("FAIL abort_latch: got %0d want 0", io.signal_latch); end
    @(negedge clk);
    aclr = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (io.valid || io.busy) nvalid++;
    end
    vectors++; if (nvalid !== 0) begin miscompares++; $display("FAIL abort_no_valid: got %0d want 0", nvalid); end
    run_window(32'd1, 32'd0, 12'h000, lat);
    vectors++; if (lat !== 13) begin miscompares++; $display("FAIL abort_next_latency: got %0d want 13", lat); end
    vectors++; if (io.hit_count !== 4'd1) begin miscompares++; $display("FAIL abort_next_count: got %0d want 1", io.hit_count); end
    vectors++; if (io.signal_latch !== 32'd1) begin miscompares++; $display("FAIL abort_next_latch: got %0d want 1", io.signal_latch); end
  endtask

  task automatic test_extremes();
    int lat;
    do_reset();
    run_window(32'hFFFF_FFFF, 32'hFFFF_FFFF, 12'hFFF, lat);
    vectors++; if (lat !== 13) begin miscompares++; $display("FAIL ext_ones_latency: got %0d want 13", lat); end
    vectors++; if (io.hit !== 1'b0) begin miscompares++; $display("FAIL ext_ones_hit: got %0b want 0", io.hit); end
    vectors++; if (io.signal_latch !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL ext_ones_latch: got %0h want ffffffff", io.signal_latch); end
    run_window(32'd1, 32'h0001_2345, 12'h000, lat);
    vectors++; if (io.hit !== 1'b1) begin miscompares++; $display("FAIL ext_thres0_hit: got %0b want 1", io.hit); end
    run_window(32'd0, 32'd0, 12'h010, lat);
    vectors++; if (io.hit !== 1'b0) begin miscompares++; $display("FAIL ext_zero_hit: got %0b want 0", io.hit); end
    run_window(32'hFFFF_FFFF, 32'h0FFF_FFFF, 12'h100, lat);
    vectors++; if (io.hit !== 1'b1) begin miscompares++; $display("FAIL ext_wide_above: got %0b want 1", io.hit); end
    run_window(32'hFFFF_FFFF, 32'h1000_0000, 12'h100, lat);
    vectors++; if (io.hit !== 1'b0) begin miscompares++; $display("FAIL ext_wide_below: got %0b want 0", io.hit); end
    vectors++; if (io.hit_count !== 4'd2) begin miscompares++; $display("FAIL ext_count: got %0d want 2", io.hit_count); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_threshold_equal();
    test_threshold_above();
    test_fractional();
    test_back_to_back();
    test_dropped_done();
    test_abort();
    test_extremes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
